// File: rtl/mem_responder.sv
// mem_responder: target end of the CPU load/store bus.
//
// Accepts one request at a time (valid/ready), waits WAIT_CYCLES wait states,
// then performs the load or store on an internal little-endian byte-addressed
// array (2**ADDR_W bytes, held as 32-bit words). It returns the result on a
// valid/ready response channel and holds it until the initiator consumes it.
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready    request handshake (req_ready high only in IDLE)
//   req_wr                 1 = store, 0 = load
//   req_addr, req_wdata    byte address, store data (sub-word data in low bits)
//   req_size               00 word, 01 half, 10 byte, 11 illegal
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata, rsp_err     zero-extended load data (0 on store/error), error flag
//   busy                   high whenever not IDLE
//
// Build option: define MEM_SUBWORD_EN to enable half/byte accesses. Without it
// req_size is ignored and every access is a word access with word alignment.

module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int WORDS = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        lat_wr_reg;
  logic [31:0] lat_addr_reg;
  logic [31:0] lat_wdata_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;
  logic [31:0] mem_words [WORDS];

  logic              in_idle;
  logic              do_access;
  logic              mem_we;
  logic              acc_wr;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [ADDR_W-3:0] acc_idx;
  logic [1:0]        acc_lane;
  logic [31:0]       cur_word;
  logic              acc_bad;
  logic [3:0]        acc_be;
  logic [31:0]       acc_wmerge;
  logic [31:0]       acc_rdata;
  logic [31:0]       acc_bitmask;

  assign in_idle   = (state_reg == IDLE);
  assign req_ready = in_idle;
  assign rsp_valid = (state_reg == RESP);
  assign busy      = !in_idle;
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

  // With zero wait states the access happens on the handshake edge itself, so
  // the access operands come straight from the request inputs in that case.
  assign acc_wr    = in_idle ? req_wr    : lat_wr_reg;
  assign acc_addr  = in_idle ? req_addr  : lat_addr_reg;
  assign acc_wdata = in_idle ? req_wdata : lat_wdata_reg;
  assign acc_idx   = acc_addr[ADDR_W-1:2];
  assign acc_lane  = acc_addr[1:0];
  assign cur_word  = mem_words[acc_idx];

  assign do_access = (in_idle && req_valid && (WAIT_CYCLES == 0)) ||
                     ((state_reg == WAIT) && (cnt_reg == 4'd1));
  assign mem_we    = do_access && acc_wr && !acc_bad;

`ifdef MEM_SUBWORD_EN
  logic       lat_size_reg_unused_guard;
  logic [1:0] lat_size_reg;
  logic [1:0] acc_size;
  assign acc_size = in_idle ? req_size : lat_size_reg;
  assign lat_size_reg_unused_guard = 1'b0;
`else
  logic unused_size;
  assign unused_size = ^req_size;
`endif

  always_comb begin
    acc_bad    = ((acc_addr >> ADDR_W) != 32'd0);
    acc_be     = 4'hF;
    acc_wmerge = acc_wdata;
    acc_rdata  = cur_word;
`ifdef MEM_SUBWORD_EN
    case (acc_size)
      2'b00: acc_bad = acc_bad | (acc_lane != 2'd0);
      2'b01: begin
        acc_bad    = acc_bad | acc_lane[0];
        acc_be     = acc_lane[1] ? 4'b1100 : 4'b0011;
        acc_wmerge = {2{acc_wdata[15:0]}};
        acc_rdata  = {16'h0, (acc_lane[1] ? cur_word[31:16] : cur_word[15:0])};
      end
      2'b10: begin
        acc_be     = 4'b0001 << acc_lane;
        acc_wmerge = {4{acc_wdata[7:0]}};
        acc_rdata  = {24'h0, cur_word[{acc_lane, 3'b000} +: 8]};
      end
      default: acc_bad = 1'b1;
    endcase
`else
    acc_bad = acc_bad | (acc_lane != 2'd0);
`endif
  end

  assign acc_bitmask = {{8{acc_be[3]}}, {8{acc_be[2]}}, {8{acc_be[1]}}, {8{acc_be[0]}}};

  // One register per word so reset can clear the whole array asynchronously.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    logic [31:0] word_reg;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        word_reg <= '0;
      end else if (mem_we && (acc_idx == (ADDR_W-2)'(gi))) begin
        word_reg <= (word_reg & ~acc_bitmask) | (acc_wmerge & acc_bitmask);
      end
    end
    assign mem_words[gi] = word_reg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      lat_wr_reg    <= 1'b0;
      lat_addr_reg  <= '0;
      lat_wdata_reg <= '0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
`ifdef MEM_SUBWORD_EN
      lat_size_reg  <= '0;
`endif
    end else begin
      if (do_access) begin
        rdata_reg <= (acc_bad || acc_wr) ? 32'd0 : acc_rdata;
        err_reg   <= acc_bad;
      end
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            lat_wr_reg    <= req_wr;
            lat_addr_reg  <= req_addr;
            lat_wdata_reg <= req_wdata;
`ifdef MEM_SUBWORD_EN
            lat_size_reg  <= req_size;
`endif
            if (WAIT_CYCLES == 0) begin
              state_reg <= RESP;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= 4'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) state_reg <= RESP;
        end
        RESP: begin
          if (rsp_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int ADDR_W = 8;
  localparam int NBYTES = 2 ** ADDR_W;

  logic        clock = 1'b0;
  logic        reset      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_wr     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [1:0]  req_size   [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];
  logic        busy       [2];

  int checks   = 0;
  int failures = 0;
  logic [7:0] mem_model [2][NBYTES];
  int wait_of [2] = '{1, 3};

  always #5 clock = ~clock;

  mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(1)) dut (
    .clock(clock), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_size(req_size[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(3)) dut3 (
    .clock(clock), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_size(req_size[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain byte array, access width and legality from the size rules.
  task automatic model_access(input int d, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size,
                              output logic [31:0] rd, output bit err);
    int n;
    err = 0;
    rd  = 0;
`ifdef MEM_SUBWORD_EN
    case (size)
      2'b00:   n = 4;
      2'b01:   n = 2;
      2'b10:   n = 1;
      default: begin n = 4; err = 1; end
    endcase
`else
    n = 4;
`endif
    if (addr >= NBYTES) err = 1;
    if (addr % n != 0) err = 1;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        if (wr) mem_model[d][int'(addr) + i] = wdata[8*i +: 8];
        else    rd[8*i +: 8] = mem_model[d][int'(addr) + i];
      end
    end
  endtask

  task automatic clear_model(input int d);
    for (int i = 0; i < NBYTES; i++) mem_model[d][i] = 8'h00;
  endtask

  // Called #1 after a rising edge; returns #1 after the consuming edge.
  task automatic txn(input int d, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size,
                     input int stall, output logic [31:0] got_rd, output bit got_err);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          lat;
    int          exp_lat;
    logic [31:0] held_rd;
    logic        held_err;
    model_access(d, wr, addr, wdata, size, exp_rd, exp_err);
    exp_lat = (wait_of[d] > 1) ? wait_of[d] : 1;
    check("req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1; req_wr[d] = wr; req_addr[d] = addr;
    req_wdata[d] = wdata; req_size[d] = size; rsp_ready[d] = 0;
    @(posedge clock); #1;
    // Garbage on the request bus outside IDLE must be ignored.
    req_wr[d] = ~wr; req_addr[d] = $urandom; req_wdata[d] = $urandom;
    req_size[d] = 2'($urandom_range(0, 3));
    lat = 0;
    while (!rsp_valid[d] && lat < 20) begin
      check("busy_wait", 32'(busy[d]), 32'd1);
      check("req_ready_wait", 32'(req_ready[d]), 32'd0);
      @(posedge clock); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("rsp_rdata", rsp_rdata[d], exp_rd);
    check("rsp_err", 32'(rsp_err[d]), 32'(exp_err));
    got_rd = rsp_rdata[d]; got_err = rsp_err[d];
    held_rd = rsp_rdata[d]; held_err = rsp_err[d];
    for (int s = 0; s < stall; s++) begin
      @(posedge clock); #1;
      check("stall_valid", 32'(rsp_valid[d]), 32'd1);
      check("stall_rdata", rsp_rdata[d], held_rd);
      check("stall_err", 32'(rsp_err[d]), 32'(held_err));
      check("stall_req_ready", 32'(req_ready[d]), 32'd0);
      check("stall_busy", 32'(busy[d]), 32'd1);
    end
    rsp_ready[d] = 1;
    @(posedge clock); #1;
    rsp_ready[d] = 0; req_valid[d] = 0;
    check("post_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    check("post_req_ready", 32'(req_ready[d]), 32'd1);
    check("post_busy", 32'(busy[d]), 32'd0);
    $display("txn d=%0d wr=%0d addr=%h wdata=%h size=%0d lat=%0d rdata=%h err=%0d",
             d, wr, addr, wdata, size, lat, got_rd, got_err);
  endtask

  initial begin
    logic [31:0] rd;
    bit          er;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1; req_valid[d] = 0; req_wr[d] = 0; req_addr[d] = 0;
      req_wdata[d] = 0; req_size[d] = 0; rsp_ready[d] = 0;
      clear_model(d);
    end
    repeat (2) @(posedge clock);
    #1;
    reset[0] = 0; reset[1] = 0;
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", 32'(req_ready[d]), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      check("rst_rsp_rdata", rsp_rdata[d], 32'd0);
      check("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
      check("rst_busy", 32'(busy[d]), 32'd0);
    end

    txn(0, 0, 32'h04, 32'h0, 2'b00, 0, rd, er);
    check("dir_rd04", rd, 32'h0);
    txn(0, 1, 32'h10, 32'hDEADBEEF, 2'b00, 0, rd, er);
    check("dir_st10_rd", rd, 32'h0);
    txn(0, 0, 32'h10, 32'h0, 2'b00, 0, rd, er);
    check("dir_ld10", rd, 32'hDEADBEEF);
`ifdef MEM_SUBWORD_EN
    txn(0, 1, 32'h11, 32'h000000AA, 2'b10, 0, rd, er);
    txn(0, 0, 32'h10, 32'h0, 2'b00, 0, rd, er);
    check("dir_ld10_byte", rd, 32'hDEADAAEF);
    txn(0, 0, 32'h12, 32'h0, 2'b01, 0, rd, er);
    check("dir_ldh12", rd, 32'h0000DEAD);
    txn(0, 0, 32'h10, 32'h0, 2'b11, 0, rd, er);
    check("dir_illegal_err", 32'(er), 32'd1);
`endif
    txn(0, 0, 32'h12, 32'h0, 2'b00, 0, rd, er);
    check("dir_mis_err", 32'(er), 32'd1);
    check("dir_mis_rd", rd, 32'h0);
    txn(0, 1, 32'h100, 32'h12345678, 2'b00, 0, rd, er);
    check("dir_oor_err", 32'(er), 32'd1);
    txn(0, 0, 32'h00, 32'h0, 2'b00, 0, rd, er);
    check("dir_ld00", rd, 32'h0);
    txn(0, 0, 32'h10, 32'h0, 2'b00, 3, rd, er);

    for (int t = 0; t < 80; t++) begin
      int mode;
      mode = $urandom_range(0, 9);
      if (mode < 7) begin
        a = 32'($urandom_range(0, 31));
        if (mode < 4) a[1:0] = 2'b00;
      end else if (mode < 9) begin
        a = 32'h100 + 32'($urandom_range(0, 255));
      end else begin
        a = $urandom;
      end
      txn(0, 1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
          $urandom_range(0, 2), rd, er);
    end

    // Three wait states.
    txn(1, 1, 32'h24, 32'hCAFEF00D, 2'b00, 0, rd, er);
    txn(1, 0, 32'h24, 32'h0, 2'b00, 1, rd, er);
    check("w3_ld24", rd, 32'hCAFEF00D);
    // Reset during WAIT drops the store; reset also clears storage.
    req_valid[1] = 1; req_wr[1] = 1; req_addr[1] = 32'h20;
    req_wdata[1] = 32'h55; req_size[1] = 2'b00;
    @(posedge clock); #1;
    req_valid[1] = 0;
    @(posedge clock); #1;
    check("w3_busy_in_wait", 32'(busy[1]), 32'd1);
    reset[1] = 1;
    #2;
    check("w3_rst_busy", 32'(busy[1]), 32'd0);
    check("w3_rst_req_ready", 32'(req_ready[1]), 32'd1);
    check("w3_rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    @(posedge clock); #1;
    reset[1] = 0;
    clear_model(1);
    repeat (4) begin
      @(posedge clock); #1;
      check("w3_no_rsp", 32'(rsp_valid[1]), 32'd0);
    end
    txn(1, 0, 32'h20, 32'h0, 2'b00, 0, rd, er);
    check("w3_ld20", rd, 32'h0);
    txn(1, 0, 32'h24, 32'h0, 2'b00, 0, rd, er);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
